// File: rtl/pc_ctrl_pkg.sv
// Shared opcode encodings and default widths for the next-PC selector.
package pc_ctrl_pkg;

  localparam int DEF_PC_W        = 8;
  localparam int DEF_OP_W        = 4;
  localparam int DEF_ALU_W       = 4;
  localparam int DEF_STACK_DEPTH = 4;

  localparam logic [3:0] OP_BEQ  = 4'b0101;
  localparam logic [3:0] OP_BNE  = 4'b0110;
  localparam logic [3:0] OP_JMP  = 4'b0111;
  localparam logic [3:0] OP_CALL = 4'b1000;
  localparam logic [3:0] OP_RET  = 4'b1001;

endpackage

// File: rtl/pc_control_if.sv
// Bundle between decoder/ALU (master) and the next-PC selector (slave).
interface pc_control_if
  import pc_ctrl_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int OP_W  = DEF_OP_W,
  parameter int ALU_W = DEF_ALU_W
);

  logic [PC_W-1:0]  PC_now;
  logic [OP_W-1:0]  op_code;
  logic [PC_W-1:0]  inst_addr;
  logic [ALU_W-1:0] ALU;
  logic [PC_W-1:0]  PC_next;

  modport master (output PC_now, output op_code, output inst_addr, output ALU, input PC_next);
  modport slave  (input PC_now, input op_code, input inst_addr, input ALU, output PC_next);

endinterface

// File: rtl/pc_branch_cond.sv
// Decides whether the instruction redirects to inst_addr (BEQ/BNE/JMP, plus CALL
// when PC_CALL_STACK_EN is defined).
module pc_branch_cond
  import pc_ctrl_pkg::*;
#(
  parameter int OP_W  = DEF_OP_W,
  parameter int ALU_W = DEF_ALU_W
) (
  input  logic [OP_W-1:0]  op_code,
  input  logic [ALU_W-1:0] ALU,
  output logic             take_branch
);

  logic alu_zero;

  assign alu_zero = (ALU == '0);

  always_comb begin
    // NOTE: every path assigns take_branch through the default first, so no latch is inferred.
    take_branch = 1'b0;
    case (op_code)
      OP_BEQ:  take_branch = alu_zero;
      OP_BNE:  take_branch = !alu_zero;
      OP_JMP:  take_branch = 1'b1;
`ifdef PC_CALL_STACK_EN
      OP_CALL: take_branch = 1'b1;
`endif
      default: take_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_control.sv
// Registered next-PC selector. Define PC_CALL_STACK_EN to add a circular
// return-address stack driven by CALL/RET.
module pc_control
  import pc_ctrl_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int OP_W  = DEF_OP_W,
  parameter int ALU_W = DEF_ALU_W
`ifdef PC_CALL_STACK_EN
  ,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
`endif
) (
  input  logic        clk,
  input  logic        rst,
  pc_control_if.slave bus
);

  logic            take_branch;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] next_pc;

  pc_branch_cond #(
    .OP_W  (OP_W),
    .ALU_W (ALU_W)
  ) u_branch_cond (
    .op_code     (bus.op_code),
    .ALU         (bus.ALU),
    .take_branch (take_branch)
  );

  // Wraps modulo 2^PC_W by truncation.
  assign pc_inc = bus.PC_now + 1'b1;

`ifdef PC_CALL_STACK_EN
  localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0] sp;      // next slot to write; top of stack is sp-1
  logic [SP_W:0]   count;
  logic [SP_W-1:0] sp_inc;
  logic [SP_W-1:0] sp_dec;
  logic            is_call;
  logic            do_pop;

  assign sp_inc  = (sp == SP_W'(STACK_DEPTH - 1)) ? '0 : sp + 1'b1;
  assign sp_dec  = (sp == '0) ? SP_W'(STACK_DEPTH - 1) : sp - 1'b1;
  assign is_call = (bus.op_code == OP_CALL);
  assign do_pop  = (bus.op_code == OP_RET) && (count != '0);

  always_comb begin
    next_pc = pc_inc;
    if (take_branch) next_pc = bus.inst_addr;
    else if (do_pop) next_pc = stack_mem[sp_dec];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp    <= '0;
      count <= '0;
    end else if (is_call) begin
      sp <= sp_inc;
      // Full stack overwrites the oldest entry; depth saturates.
      if (count != (SP_W + 1)'(STACK_DEPTH)) count <= count + 1'b1;
    end else if (do_pop) begin
      sp    <= sp_dec;
      count <= count - 1'b1;
    end
  end

  // NOTE: storage is not reset; count==0 makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (!rst && is_call) stack_mem[sp] <= pc_inc;
  end
`else
  always_comb begin
    next_pc = take_branch ? bus.inst_addr : pc_inc;
  end
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) bus.PC_next <= '0;
    else     bus.PC_next <= next_pc;
  end

endmodule

// File: tb/tb_pc_control.sv
// Directed-vector bench for pc_control; the stack section follows PC_CALL_STACK_EN.
module tb_pc_control;
  import pc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  pc_control_if bus ();

  pc_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
  endtask

  // Apply one instruction, let one edge pass, then compare PC_next.
  task automatic step(input string tag, input logic r, input logic [3:0] op,
                      input logic [7:0] pc, input logic [7:0] addr,
                      input logic [3:0] alu, input logic [7:0] exp);
    rst           = r;
    bus.op_code   = op;
    bus.PC_now    = pc;
    bus.inst_addr = addr;
    bus.ALU       = alu;
    @(posedge clk);
    #1;
    check(tag, bus.PC_next, exp);
  endtask

  initial begin
    bus.op_code   = 4'h0;
    bus.PC_now    = 8'h00;
    bus.inst_addr = 8'h00;
    bus.ALU       = 4'h0;
    #2;

    step("reset_0", 1'b1, 4'h0, 8'h33, 8'h44, 4'h0, 8'h00);
    step("reset_1", 1'b1, 4'h0, 8'h33, 8'h44, 4'h0, 8'h00);

    for (int i = 0; i < 6; i++)
      step($sformatf("seq_%0d", i), 1'b0, 4'h0, 8'(i), 8'h00, 4'h0, 8'(i + 1));

    step("beq_taken",     1'b0, OP_BEQ, 8'h05, 8'h00, 4'h0, 8'h00);
    step("bne_not_taken", 1'b0, OP_BNE, 8'h05, 8'h00, 4'h0, 8'h06);
    step("bne_taken",     1'b0, OP_BNE, 8'h05, 8'h00, 4'h1, 8'h00);
    step("bne_taken_5",   1'b0, OP_BNE, 8'h05, 8'h05, 4'h1, 8'h05);
    step("beq_msb_alu",   1'b0, OP_BEQ, 8'h05, 8'h00, 4'h8, 8'h06);
    step("bne_msb_alu",   1'b0, OP_BNE, 8'h05, 8'h77, 4'h8, 8'h77);

    step("wrap",          1'b0, 4'h0,   8'hFF, 8'h00, 4'h0, 8'h00);
    step("jmp",           1'b0, OP_JMP, 8'hFF, 8'h3C, 4'h7, 8'h3C);
    step("beq_nt_3",      1'b0, OP_BEQ, 8'h3C, 8'h90, 4'h3, 8'h3D);
    step("other_op_f",    1'b0, 4'hF,   8'h20, 8'h90, 4'h0, 8'h21);

    step("mid_reset",     1'b1, OP_BEQ, 8'h12, 8'h40, 4'h0, 8'h00);
    step("post_reset",    1'b0, OP_BEQ, 8'h12, 8'h40, 4'h0, 8'h40);

`ifdef PC_CALL_STACK_EN
    step("ret_empty",     1'b0, OP_RET,  8'h30, 8'h99, 4'h0, 8'h31);
    step("call",          1'b0, OP_CALL, 8'h10, 8'h80, 4'h0, 8'h80);
    step("ret",           1'b0, OP_RET,  8'h80, 8'h00, 4'h0, 8'h11);
    for (int i = 0; i < 5; i++)
      step($sformatf("call5_%0d", i), 1'b0, OP_CALL, 8'(8'h20 + i), 8'(8'hA0 + i), 4'h0,
           8'(8'hA0 + i));
    for (int i = 0; i < 4; i++)
      step($sformatf("ret5_%0d", i), 1'b0, OP_RET, 8'h50, 8'h00, 4'h0, 8'(8'h25 - i));
    step("ret5_empty",    1'b0, OP_RET,  8'h50, 8'h00, 4'h0, 8'h51);
    step("stack_rst",     1'b0, OP_CALL, 8'h60, 8'h70, 4'h0, 8'h70);
    step("stack_rst_1",   1'b1, 4'h0,    8'h00, 8'h00, 4'h0, 8'h00);
    step("ret_after_rst", 1'b0, OP_RET,  8'h08, 8'h00, 4'h0, 8'h09);
`else
    step("call_disabled", 1'b0, OP_CALL, 8'h10, 8'h80, 4'h0, 8'h11);
    step("ret_disabled",  1'b0, OP_RET,  8'h11, 8'h80, 4'h0, 8'h12);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_control.md
Name: pc_control

Overview:
- Next-program-counter selector for the 8-bit MIPS-style processor core.
- Takes the current PC, decoded opcode, instruction target address and ALU result, and produces the next PC.
- Output is registered: one clock of latency, synchronous reset.
- Sits between the instruction decoder/ALU and the PC register feeding instruction memory.

Parameters:
- PC_W, 8, width of PC_now, inst_addr and PC_next.
- OP_W, 4, width of op_code.
- ALU_W, 4, width of the ALU result input.
- STACK_DEPTH, 4, return-address stack entries. Used only with PC_CALL_STACK_EN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- PC_now  input  PC_W  current program counter.
- op_code  input  OP_W  opcode of the current instruction.
- inst_addr  input  PC_W  absolute branch/jump target from the instruction.
- ALU  input  ALU_W  ALU result for the current instruction; zero test = (ALU == 0).
- PC_next  output  PC_W  registered next program counter.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: on a rising clk with rst=1, PC_next <= 0 (and the stack, if present, is emptied). rst overrides all other inputs.
- Latency: PC_next on edge N+1 reflects the inputs sampled at edge N.
- Combinational select, computed from the sampled inputs:
  - op 4'b0101 (BEQ): inst_addr if ALU==0, else PC_now+1.
  - op 4'b0110 (BNE): inst_addr if ALU!=0, else PC_now+1.
  - op 4'b0111 (JMP): inst_addr unconditionally.
  - all other opcodes, including 4'b0000: PC_now+1.
- Arithmetic: PC_now+1 is modulo 2^PC_W, so 8'hFF -> 8'h00. There is no carry-out and no error.
- Targets: inst_addr is an absolute target used as-is; no offset addition and no alignment check.
- Only the full ALU value matters; no individual flag bits are decoded.
- X/unknown inputs need no special handling; the design must not latch (fully specified combinational case with a default).

Optional Feature:
- Macro: PC_CALL_STACK_EN.
- With the macro defined, a return-address stack of STACK_DEPTH x PC_W entries is added:
  - op 4'b1000 (CALL): PC_next <= inst_addr; push PC_now+1 (mod 2^PC_W).
  - op 4'b1001 (RET): PC_next <= top of stack; pop.
  - Push when full: the oldest entry is overwritten (circular), depth stays at STACK_DEPTH.
  - Pop when empty: PC_next <= PC_now+1 and the stack is unchanged.
  - The stack pointer and count update on the same edge as PC_next.
  - rst clears the count to 0.
- Without the macro: ops 1000/1001 fall into the default case (PC_now+1) and no stack storage exists.

Decomposition:
- Package pc_ctrl_pkg holds:
  - opcode localparams OP_BEQ=4'b0101, OP_BNE=4'b0110, OP_JMP=4'b0111, OP_CALL=4'b1000, OP_RET=4'b1001;
  - the default widths.
- Sub-module pc_branch_cond: purely combinational.
  - Inputs op_code and ALU.
  - Outputs take_branch (1 for taken BEQ/BNE/JMP/CALL).
  - pc_control instantiates it and owns the adder, mux, output register and optional stack.

Test Plan:
- Sequential + reset: rst=1 for 2 cycles -> PC_next=0. Then rst=0, op=0, PC_now=0..5 applied per cycle -> PC_next=1..6, each one cycle later.
- Branch conditions, with PC_now=5, inst_addr=0:
  - op=0101, ALU=0 -> PC_next=0.
  - op=0110, ALU=0 -> PC_next=6.
  - op=0110, ALU=1 -> PC_next=0.
  - op=0110, ALU=1, inst_addr=5 -> PC_next=5.
- Wrap and jump: PC_now=8'hFF, op=0 -> PC_next=8'h00. op=0111, inst_addr=8'h3C, ALU=7 -> PC_next=8'h3C. op=0101, ALU=3 -> PC_next=PC_now+1.
- Mid-operation reset: during a taken branch (op=0101, ALU=0, inst_addr=8'h40) assert rst -> PC_next=0 on that edge. Deassert -> normal selection resumes the next cycle.
- Stack (PC_CALL_STACK_EN):
  - CALL at PC_now=8'h10 to 8'h80 -> PC_next=8'h80.
  - RET -> 8'h11.
  - Five CALLs (depth 4), then five RETs -> the four newest return addresses come back in LIFO order; the 5th RET (stack empty) gives PC_now+1.
- Stack disabled: without the macro, op=1000 at PC_now=8'h10 -> PC_next=8'h11.
